// File: rtl/mac_drv_pkg.sv
// Shared widths, state encoding and result record for the mac driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_drv_pkg;

    localparam int MAC_BW    = 8;
    localparam int ACC_BW    = 2 * MAC_BW + 4;
    localparam int CNT_BW    = 8;
    // Guard bits in ACC_BW cover this many full-scale terms; beyond it the sum may wrap.
    localparam int OVF_TERMS = 16;

    // Dot-product framing state: IDLE = no product open, ACC = product open.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_ACC  = 1'b1;

    // One completed dot product as stored in the result FIFO.
    typedef struct packed {
        logic [ACC_BW-1:0] data;
        logic [CNT_BW-1:0] cnt;
        logic              ovf;
    } res_t;

    localparam int RES_W = ACC_BW + CNT_BW + 1;

    // Term counter increment that sticks at all-ones.
    function automatic logic [CNT_BW-1:0] cnt_sat_inc(input logic [CNT_BW-1:0] c);
        return (c == '1) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/mac_drv_if.sv
// Operand stream, mac hookup and result stream of the mac driver.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes.
interface mac_drv_if;
    import mac_drv_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MAC_BW-1:0] in_a;
    logic [MAC_BW-1:0] in_b;
    logic              in_last;

    logic [MAC_BW-1:0] mac_a;
    logic [MAC_BW-1:0] mac_b;
    logic [ACC_BW-1:0] mac_c;
    logic              mac_acc_en;
    logic [ACC_BW-1:0] mac_oc;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_BW-1:0] out_data;
    logic [CNT_BW-1:0] out_cnt;
    logic              out_ovf;

    // Driver side (the mac_drv block itself).
    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_oc, out_ready,
        output in_ready, mac_a, mac_b, mac_c, mac_acc_en,
               out_valid, out_data, out_cnt, out_ovf
    );

    // Environment side: operand source, mac instance and result sink.
    modport master (
        output in_valid, in_a, in_b, in_last, mac_oc, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, mac_acc_en,
               out_valid, out_data, out_cnt, out_ovf
    );

endinterface

// File: rtl/mac_res_fifo.sv
// Small synchronous FIFO holding completed dot-product results.
// Latency: write at cycle t is visible on rd_dat_o at t+1.
// Backpressure: wr_rdy_o low when full; simultaneous read+write keeps count.
module mac_res_fifo #(
    parameter  int WIDTH = 29,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_vld_i,
    output logic             wr_rdy_o,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             rd_vld_o,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_rdy_o = (cnt_q != CNT_W'(DEPTH));
    assign rd_vld_o = (cnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = cnt_q;
    assign do_wr    = wr_vld_i & wr_rdy_o;
    assign do_rd    = rd_rdy_i & rd_vld_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed when count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/mac_drv.sv
// Frames an operand stream into dot products on an external registered mac.
// Latency: last term accepted at cycle t -> result at out_valid from cycle t+2.
// Backpressure: in_ready drops when FIFO entries plus pending capture fill RES_DEPTH.
module mac_drv
    import mac_drv_pkg::*;
#(
    parameter int RES_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    mac_drv_if.slave  bus
);

    localparam int FCNT_W = $clog2(RES_DEPTH + 1);

    state_t            state_q, state_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic              accept;
    logic              in_ready;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_wr_rdy;
    logic              fifo_rd_vld;
    logic              out_valid;
    res_t              wr_res;
    res_t              head;

    // A slot is reserved for the capture in flight, so a new last term can never overrun.
    assign in_ready = ~rst && ((int'(fifo_cnt) + int'(pend_q)) < RES_DEPTH);
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready   = in_ready;
    // Idle cycles feed 0*0 with accumulate on, so the mac simply holds its value.
    assign bus.mac_a      = accept ? bus.in_a : '0;
    assign bus.mac_b      = accept ? bus.in_b : '0;
    assign bus.mac_c      = '0;
    assign bus.mac_acc_en = ~(accept && (state_q == ST_IDLE));

    // Framing state, term count and capture request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        if (accept) begin
            cnt_d   = (state_q == ST_IDLE) ? CNT_BW'(1) : cnt_sat_inc(cnt_q);
            state_d = bus.in_last ? ST_IDLE : ST_ACC;
            pend_d  = bus.in_last;
        end
    end

    // Reset drops any open product and any capture not yet written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // The mac result for the last term appears one cycle after its accept; cnt_q still
    // holds this product's count even if a new product starts in the same cycle.
    assign wr_res.data = bus.mac_oc;
    assign wr_res.cnt  = cnt_q;
    assign wr_res.ovf  = (cnt_q > CNT_BW'(OVF_TERMS));

    mac_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .wr_vld_i (pend_q),
        .wr_rdy_o (fifo_wr_rdy),
        .wr_dat_i (wr_res),
        .rd_vld_o (fifo_rd_vld),
        .rd_rdy_i (bus.out_ready & ~rst),
        .rd_dat_o (head),
        .count_o  (fifo_cnt)
    );

    assign out_valid     = fifo_rd_vld & ~rst & (fifo_wr_rdy | 1'b1);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head.data : '0;
    assign bus.out_cnt   = out_valid ? head.cnt  : '0;
    assign bus.out_ovf   = out_valid ? head.ovf  : 1'b0;

endmodule

// File: tb/tb_mac_drv.sv
`timescale 1ns/1ps
module tb_mac_drv;
    import mac_drv_pkg::*;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic mac_rst = 1'b1;
    int   n_chk   = 0;
    int   n_err   = 0;

    mac_drv_if bus();

    mac_drv #(.RES_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference mac: oC <= (acc_en ? oC : iC) + iA*iB, with its own reset.
    logic [ACC_BW-1:0] mac_q;
    always_ff @(posedge clk) begin
        if (mac_rst) mac_q <= '0;
        else         mac_q <= (bus.mac_acc_en ? mac_q : bus.mac_c)
                              + ACC_BW'(bus.mac_a) * ACC_BW'(bus.mac_b);
    end
    assign bus.mac_oc = mac_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs for this cycle and move to the sampling point (negedge).
    task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = l;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // ---- reset state
        nxt(); nxt();
        apply(0, 0, 0, 0);
        chk("rst_in_ready",  32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_out_cnt",   32'(bus.out_cnt), 0);
        chk("rst_out_ovf",   32'(bus.out_ovf), 0);
        nxt();
        rst = 1'b0; mac_rst = 1'b0;
        apply(0, 0, 0, 0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("idle_mac_a",        32'(bus.mac_a), 0);
        chk("mac_c_zero",        32'(bus.mac_c), 0);
        nxt();

        // ---- (2,3),(4,5),(6,7,last) -> 68, cnt 3, valid at t+2
        bus.out_ready = 1'b1;
        apply(1, 2, 3, 0);
        chk("dp3_first_acc_en", 32'(bus.mac_acc_en), 0);
        chk("dp3_first_mac_a",  32'(bus.mac_a), 2);
        chk("dp3_first_mac_b",  32'(bus.mac_b), 3);
        nxt();
        apply(1, 4, 5, 0);
        chk("dp3_mid_acc_en", 32'(bus.mac_acc_en), 1);
        nxt();
        apply(1, 6, 7, 1);
        chk("dp3_last_acc_en", 32'(bus.mac_acc_en), 1);
        nxt();
        apply(0, 0, 0, 0);
        chk("dp3_t1_no_valid", 32'(bus.out_valid), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("dp3_t2_valid", 32'(bus.out_valid), 1);
        chk("dp3_data",     32'(bus.out_data), 68);
        chk("dp3_cnt",      32'(bus.out_cnt), 3);
        chk("dp3_ovf",      32'(bus.out_ovf), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("dp3_drained", 32'(bus.out_valid), 0);
        nxt();

        // ---- (255,255,last) then (1,1,last) back to back
        apply(1, 255, 255, 1);
        chk("single_acc_en", 32'(bus.mac_acc_en), 0);
        nxt();
        apply(1, 1, 1, 1);
        chk("single2_acc_en",   32'(bus.mac_acc_en), 0);
        chk("single2_in_ready", 32'(bus.in_ready), 1);
        nxt();
        apply(0, 0, 0, 0);
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_data",  32'(bus.out_data), 65025);
        chk("single_cnt",   32'(bus.out_cnt), 1);
        nxt();
        apply(0, 0, 0, 0);
        chk("single2_valid", 32'(bus.out_valid), 1);
        chk("single2_data",  32'(bus.out_data), 1);
        chk("single2_cnt",   32'(bus.out_cnt), 1);
        nxt();

        // ---- (2,3), 4 idle cycles, (4,5,last) -> 26
        apply(1, 2, 3, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            apply(0, 9, 9, 1);
            chk("gap_idle_acc_en", 32'(bus.mac_acc_en), 1);
            nxt();
        end
        apply(1, 4, 5, 1);
        nxt();
        apply(0, 0, 0, 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("gap_valid", 32'(bus.out_valid), 1);
        chk("gap_data",  32'(bus.out_data), 26);
        chk("gap_cnt",   32'(bus.out_cnt), 2);
        nxt();

        // ---- out_ready=0: three single-term products, two buffered
        bus.out_ready = 1'b0;
        apply(1, 1, 1, 1);
        nxt();
        apply(1, 2, 2, 1);
        chk("bp_second_ready", 32'(bus.in_ready), 1);
        nxt();
        apply(1, 3, 3, 1);
        chk("bp_third_blocked", 32'(bus.in_ready), 0);
        nxt();
        apply(1, 3, 3, 1);
        chk("bp_full_ready", 32'(bus.in_ready), 0);
        chk("bp_head_valid", 32'(bus.out_valid), 1);
        chk("bp_head_data",  32'(bus.out_data), 1);
        nxt();
        apply(1, 3, 3, 1);
        chk("bp_head_stable", 32'(bus.out_data), 1);
        nxt();
        bus.out_ready = 1'b1;
        apply(1, 3, 3, 1);
        chk("bp_drain0_data",  32'(bus.out_data), 1);
        chk("bp_drain0_ready", 32'(bus.in_ready), 0);
        nxt();
        apply(1, 3, 3, 1);
        chk("bp_drain1_data",  32'(bus.out_data), 4);
        chk("bp_drain1_ready", 32'(bus.in_ready), 1);
        nxt();
        apply(0, 0, 0, 0);
        chk("bp_gap_valid", 32'(bus.out_valid), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("bp_third_valid", 32'(bus.out_valid), 1);
        chk("bp_third_data",  32'(bus.out_data), 9);
        nxt();

        // ---- 16 terms: boundary, no overflow flag
        for (int i = 0; i < 16; i++) begin
            apply(1, 1, 1, 1'(i == 15));
            nxt();
        end
        apply(0, 0, 0, 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("t16_data", 32'(bus.out_data), 16);
        chk("t16_cnt",  32'(bus.out_cnt), 16);
        chk("t16_ovf",  32'(bus.out_ovf), 0);
        nxt();

        // ---- 17 full-scale terms: 17*65025 = 1105425, minus 2^20 = 56849
        for (int i = 0; i < 17; i++) begin
            apply(1, 255, 255, 1'(i == 16));
            nxt();
        end
        apply(0, 0, 0, 0);
        chk("t17_t1_no_valid", 32'(bus.out_valid), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("t17_valid", 32'(bus.out_valid), 1);
        chk("t17_data",  32'(bus.out_data), (17 * 65025) % (1 << 20));
        chk("t17_cnt",   32'(bus.out_cnt), 17);
        chk("t17_ovf",   32'(bus.out_ovf), 1);
        nxt();

        // ---- reset mid-product, then (3,3,last) -> 9
        apply(1, 5, 5, 0);
        nxt();
        apply(1, 7, 7, 0);
        nxt();
        rst = 1'b1;
        apply(0, 0, 0, 0);
        chk("mid_rst_in_ready",  32'(bus.in_ready), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        nxt();
        rst = 1'b0;
        apply(1, 3, 3, 1);
        chk("post_rst_acc_en", 32'(bus.mac_acc_en), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("post_rst_no_stale", 32'(bus.out_valid), 0);
        nxt();
        apply(0, 0, 0, 0);
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_data",  32'(bus.out_data), 9);
        chk("post_rst_cnt",   32'(bus.out_cnt), 1);
        nxt();
        apply(0, 0, 0, 0);
        chk("post_rst_empty", 32'(bus.out_valid), 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
